ctr20_core: RTL and testbench
=============================

// Module: ctr20_core
// PURPOSE
//  Upstream stage of the 2-digit 7-seg display decoder: produces the 5-bit count 0..19 it consumes.
//  Clock prescaler generates a TICK_HZ enable; a mod-20 up/down counter advances on each tick while running.
//  Two raw push-buttons (run/stop toggle, clear) and a direction switch are synchronised and edge-detected here.
// PARAMETERS
//  CLK_HZ     50_000_000  input clock frequency
//  TICK_HZ    1           count rate; DIV = CLK_HZ/TICK_HZ, DIV >= 2 (elaboration error otherwise)
//  DB_CYCLES  1_000_000   debounce stable-time in clk cycles (used only with CTR20_DEBOUNCE_EN)
// PORTS
//  clk        in   1  system clock; all state on rising edge
//  rst_n      in   1  reset: asynchronous assert, active-low
//  btn_run_n  in   1  raw run/stop key, active-low, asynchronous to clk
//  btn_clr_n  in   1  raw clear key, active-low, asynchronous to clk
//  dir        in   1  raw switch: 1 = count up, 0 = count down
//  state      out  5  current count, always 0..19 (feeds the display decoder)
//  run        out  1  1 = counting enabled
//  tick       out  1  1-cycle pulse on each count step
//  wrap       out  1  1-cycle pulse, same cycle as the tick that crosses 19->0 (up) or 0->19 (down)
// BEHAVIOUR
//  Reset (rst_n=0): state=0, run=0, tick=0, wrap=0, prescaler=0, sync/edge flops=1 (key released), dir sync=1.
//  Inputs: each passes a 2-flop synchroniser; key press = registered falling edge of synced level.
//  Press latency (no debounce): key low at edge N -> run/clr action visible at output after edge N+3.
//  Run key press: run <= ~run. Prescaler holds its value while run=0 (pause preserves phase).
//  Clear key press: state<=0, prescaler<=0, tick/wrap suppressed that cycle; run unchanged.
//  Prescaler: counts 0..DIV-1 while run=1; at DIV-1 -> 0 and tick=1 for one cycle.
//  On tick: dir_s=1: state = (state==19) ? 0 : state+1; dir_s=0: state = (state==0) ? 19 : state-1.
//  wrap=1 only on the 19->0 (up) or 0->19 (down) tick.
//  Simultaneous events, same cycle: clear beats tick; clear + run press both take effect.
//  Run press on the prescaler-terminal cycle: that tick still fires; run toggles after it.
//  dir change: takes effect on the first tick after it has passed the synchroniser; no effect between ticks.
//  state never leaves 0..19; defensive: any state>19 reaching a tick loads 0.
//  rst_n asserted mid-count: all outputs return to reset values immediately (asynchronous).
// CONFIGURATION
//  CTR20_DEBOUNCE_EN defined: btn_run_n and btn_clr_n each pass a debounce filter after sync;
//    the filtered level changes only after the synced level has been stable for DB_CYCLES consecutive cycles;
//    press latency = 3 + DB_CYCLES cycles; glitches shorter than DB_CYCLES produce no action.
//  Undefined: no filter; every synced falling edge is a press (3-cycle latency). dir is never debounced.
// STRUCTURE
//  Shared package: STATE_W=5, STATE_MAX=5'd19, STATE_MIN=5'd0, 7-seg code constants shared with the decoder.
//  Sub-module btn_sync_edge (one instance per key): 2-flop sync, optional debounce, registered falling-edge
//    pulse out; debounce counter width $clog2(DB_CYCLES+1).
//  Top: prescaler ($clog2(DIV) bits), run flag, mod-20 counter, dir synchroniser.
// TESTING (bench params CLK_HZ=8, TICK_HZ=1 -> DIV=8; DB_CYCLES=4)
//  Reset then idle 50 cycles -> state=0, run=0, tick never asserted.
//  Run press, dir=1, run 20 ticks -> state 0,1..19,0; tick every 8 cycles; wrap exactly once, on 19->0.
//  dir=0 from state=0, 3 ticks -> state 19,18,17; wrap on the 0->19 tick only.
//  Clear press on the prescaler-terminal cycle at state=7 -> state=0, no tick/wrap that cycle, run stays 1.
//  Run press at prescaler=3, wait 20 cycles, press again -> state frozen; next tick exactly 4 cycles after resume.
//  CTR20_DEBOUNCE_EN: 3-cycle low glitch on btn_run_n -> run unchanged; 10-cycle press -> run toggles once,
//    3+4 cycles after the key goes low.
//  rst_n low mid-count at state=12 -> state=0, run=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/ctr20_pkg.sv
// Shared types and constants for the 0..19 counter and its downstream 7-seg decoder.
package ctr20_pkg;

  localparam int unsigned STATE_W = 5;
  localparam logic [STATE_W-1:0] STATE_MAX = 5'd19;
  localparam logic [STATE_W-1:0] STATE_MIN = 5'd0;

  // Segment codes, bit order {g,f,e,d,c,b,a}, active-high
  localparam int unsigned SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b000_0000;

  typedef struct packed {
    logic [STATE_W-1:0] nxt;
    logic               wrap;
  } step_t;

  function automatic logic [SEG_W-1:0] seg_code(input logic [3:0] digit);
    logic [SEG_W-1:0] code;
    case (digit)
      4'd0:    code = 7'b011_1111;
      4'd1:    code = 7'b000_0110;
      4'd2:    code = 7'b101_1011;
      4'd3:    code = 7'b100_1111;
      4'd4:    code = 7'b110_0110;
      4'd5:    code = 7'b110_1101;
      4'd6:    code = 7'b111_1101;
      4'd7:    code = 7'b000_0111;
      4'd8:    code = 7'b111_1111;
      4'd9:    code = 7'b110_1111;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // One mod-20 step; out-of-range states recover to 0 without a wrap
  function automatic step_t step_state(input logic [STATE_W-1:0] cur, input logic up);
    step_t s;
    s.nxt  = STATE_MIN;
    s.wrap = 1'b0;
    if (cur > STATE_MAX) begin
      s.nxt = STATE_MIN;
    end else if (up) begin
      if (cur == STATE_MAX) begin
        s.nxt  = STATE_MIN;
        s.wrap = 1'b1;
      end else begin
        s.nxt = cur + 5'd1;
      end
    end else begin
      if (cur == STATE_MIN) begin
        s.nxt  = STATE_MAX;
        s.wrap = 1'b1;
      end else begin
        s.nxt = cur - 5'd1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/ctr20_core_btn_sync_edge.sv
// Raw active-low key -> 2-flop sync -> optional debounce (CTR20_DEBOUNCE_EN) -> registered press pulse.
module btn_sync_edge #(
  parameter int unsigned DB_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  if (DB_CYCLES < 1) begin : g_bad_db
    $error("btn_sync_edge: DB_CYCLES must be >= 1");
  end

  logic s1_q, s1_d, s2_q, s2_d;
  logic lvl_q, lvl_d;
  logic press_q, press_d;
  logic lvl_c;

`ifdef CTR20_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Filtered level follows the synced level only after DB_CYCLES stable cycles
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (s2_q != filt_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign lvl_c = filt_q;
`else
  assign lvl_c = s2_q;
`endif

  always_comb begin
    s1_d    = btn_n;
    s2_d    = s1_q;
    lvl_d   = lvl_c;
    press_d = lvl_q & ~lvl_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      lvl_q   <= 1'b1;
      press_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/ctr20_core.sv
// Prescaled mod-20 up/down counter with run/stop and clear keys.
// Build option: CTR20_DEBOUNCE_EN adds a DB_CYCLES debounce filter on both keys.
module ctr20_core
  import ctr20_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TICK_HZ   = 1,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_run_n,
  input  logic               btn_clr_n,
  input  logic               dir,
  output logic [STATE_W-1:0] state,
  output logic               run,
  output logic               tick,
  output logic               wrap
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W = (DIV >= 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_bad_div
    $error("ctr20_core: CLK_HZ/TICK_HZ must be >= 2");
  end

  logic run_press, clr_press;

  btn_sync_edge #(.DB_CYCLES(DB_CYCLES)) u_run_key (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_run_n),
    .press (run_press)
  );

  btn_sync_edge #(.DB_CYCLES(DB_CYCLES)) u_clr_key (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_clr_n),
    .press (clr_press)
  );

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic               run_q, run_d;
  logic               tick_q, tick_d;
  logic               wrap_q, wrap_d;
  logic               dir_s1_q, dir_s1_d, dir_s2_q, dir_s2_d;
  logic               pre_last_c;
  step_t              step_c;

  // Clear outranks the terminal tick; a run press still lets this cycle's tick fire
  always_comb begin
    dir_s1_d   = dir;
    dir_s2_d   = dir_s1_q;
    run_d      = run_q ^ run_press;
    pre_d      = pre_q;
    state_d    = state_q;
    tick_d     = 1'b0;
    wrap_d     = 1'b0;
    pre_last_c = run_q && (pre_q == PRE_W'(DIV - 1));
    step_c     = step_state(state_q, dir_s2_q);
    if (clr_press) begin
      pre_d   = '0;
      state_d = STATE_MIN;
    end else if (pre_last_c) begin
      pre_d   = '0;
      tick_d  = 1'b1;
      state_d = step_c.nxt;
      wrap_d  = step_c.wrap;
    end else if (run_q) begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      state_q  <= STATE_MIN;
      run_q    <= 1'b0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
      dir_s1_q <= 1'b1;
      dir_s2_q <= 1'b1;
    end else begin
      pre_q    <= pre_d;
      state_q  <= state_d;
      run_q    <= run_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
      dir_s1_q <= dir_s1_d;
      dir_s2_q <= dir_s2_d;
    end
  end

  assign state = state_q;
  assign run   = run_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_ctr20_core.sv
// Directed bench for ctr20_core with DIV=8, DB_CYCLES=4.
module tb_ctr20_core;

  localparam int DIV = 8;
  localparam int DB  = 4;
`ifdef CTR20_DEBOUNCE_EN
  localparam int PRESS_LAT = 4 + DB;
  localparam int HOLD      = 10;
`else
  localparam int PRESS_LAT = 4;
  localparam int HOLD      = 2;
`endif
  localparam int PLAT = PRESS_LAT - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_run_n = 1'b1;
  logic       btn_clr_n = 1'b1;
  logic       dir = 1'b1;
  logic [4:0] state;
  logic       run, tick, wrap;

  int errors = 0;
  int checks = 0;
  int run_hold = 0;
  int clr_hold = 0;
  int stray_wrap = 0;

  always #5 clk = ~clk;

  ctr20_core #(.CLK_HZ(8), .TICK_HZ(1), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_run_n (btn_run_n),
    .btn_clr_n (btn_clr_n),
    .dir       (dir),
    .state     (state),
    .run       (run),
    .tick      (tick),
    .wrap      (wrap)
  );

  task automatic step();
    @(posedge clk);
    #1;
    if (wrap && !tick) stray_wrap++;
    if (run_hold > 0) begin
      run_hold--;
      if (run_hold == 0) btn_run_n = 1'b1;
    end
    if (clr_hold > 0) begin
      clr_hold--;
      if (clr_hold == 0) btn_clr_n = 1'b1;
    end
  endtask

  task automatic press_run(input int hold);
    btn_run_n = 1'b0;
    run_hold  = hold;
  endtask

  task automatic press_clr(input int hold);
    btn_clr_n = 1'b0;
    clr_hold  = hold;
  endtask

  task automatic wait_tick(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget) begin
      step();
      n++;
      if (tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int ticks;
    step();
    step();
    checks++;
    if ({state, run, tick, wrap} !== 8'd0) begin
      errors++;
      $display("FAIL reset_vals: got state=%0d run=%0d tick=%0d wrap=%0d required all 0", state, run, tick, wrap);
    end
    rst_n = 1'b1;
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tick) ticks++;
    end
    checks++;
    if (ticks != 0) begin
      errors++;
      $display("FAIL idle_ticks: got %0d required 0", ticks);
    end
    checks++;
    if (state !== 5'd0 || run !== 1'b0) begin
      errors++;
      $display("FAIL idle_state: got state=%0d run=%0d required 0/0", state, run);
    end
  endtask

  task automatic test_count_up();
    int n;
    bit ok;
    int wraps;
    press_run(HOLD);
    for (int i = 0; i < PRESS_LAT - 1; i++) step();
    checks++;
    if (run !== 1'b0) begin
      errors++;
      $display("FAIL run_early: got %0d required 0", run);
    end
    step();
    checks++;
    if (run !== 1'b1) begin
      errors++;
      $display("FAIL run_latency: got %0d required 1", run);
    end
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      wait_tick(20, n, ok);
      checks++;
      if (!ok || n != DIV) begin
        errors++;
        $display("FAIL up_interval[%0d]: got %0d cycles (seen=%0d) required %0d", i, n, ok, DIV);
      end
      checks++;
      if (state !== 5'((i + 1) % 20)) begin
        errors++;
        $display("FAIL up_state[%0d]: got %0d required %0d", i, state, (i + 1) % 20);
      end
      checks++;
      if (wrap !== (i == 19)) begin
        errors++;
        $display("FAIL up_wrap[%0d]: got %0d required %0d", i, wrap, i == 19);
      end
      if (wrap) wraps++;
    end
    checks++;
    if (wraps != 1) begin
      errors++;
      $display("FAIL up_wrap_count: got %0d required 1", wraps);
    end
  endtask

  task automatic test_count_down();
    int  n;
    bit  ok;
    int  exp_s [3] = '{19, 18, 17};
    bit  exp_w [3] = '{1'b1, 1'b0, 1'b0};
    dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_tick(20, n, ok);
      checks++;
      if (!ok || n != DIV) begin
        errors++;
        $display("FAIL down_interval[%0d]: got %0d cycles (seen=%0d) required %0d", i, n, ok, DIV);
      end
      checks++;
      if (state !== 5'(exp_s[i]) || wrap !== exp_w[i]) begin
        errors++;
        $display("FAIL down_step[%0d]: got state=%0d wrap=%0d required %0d/%0d", i, state, wrap, exp_s[i], exp_w[i]);
      end
    end
    checks++;
    if (stray_wrap != 0) begin
      errors++;
      $display("FAIL wrap_without_tick: got %0d required 0", stray_wrap);
    end
  endtask

  task automatic test_clear_terminal();
    int n;
    bit ok;
    int ticks;
    dir = 1'b1;
    for (int i = 0; i < 25 && state !== 5'd7; i++) wait_tick(20, n, ok);
    checks++;
    if (state !== 5'd7) begin
      errors++;
      $display("FAIL clr_seek: got %0d required 7", state);
    end
    for (int i = 0; i < DIV - 1 - PLAT; i++) step();
    press_clr(HOLD);
    ticks = 0;
    for (int i = 0; i < PLAT; i++) begin
      step();
      if (tick) ticks++;
    end
    checks++;
    if (state !== 5'd7) begin
      errors++;
      $display("FAIL clr_before: got %0d required 7", state);
    end
    step();
    if (tick) ticks++;
    checks++;
    if (state !== 5'd0 || ticks != 0 || wrap !== 1'b0 || run !== 1'b1) begin
      errors++;
      $display("FAIL clr_terminal: got state=%0d ticks=%0d wrap=%0d run=%0d required 0/0/0/1", state, ticks, wrap, run);
    end
    wait_tick(20, n, ok);
    checks++;
    if (!ok || n != DIV || state !== 5'd1) begin
      errors++;
      $display("FAIL clr_restart: got %0d cycles state=%0d required %0d cycles state=1", n, state, DIV);
    end
  endtask

  task automatic test_pause();
    int   n;
    bit   ok;
    int   ticks;
    logic [4:0] frozen;
    wait_tick(20, n, ok);
    for (int i = 0; i < (((3 - PLAT) % DIV) + DIV) % DIV; i++) step();
    press_run(HOLD);
    for (int i = 0; i < PLAT + 1; i++) step();
    checks++;
    if (run !== 1'b0) begin
      errors++;
      $display("FAIL pause_run: got %0d required 0", run);
    end
    frozen = state;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick) ticks++;
    end
    checks++;
    if (state !== frozen || ticks != 0) begin
      errors++;
      $display("FAIL pause_frozen: got state=%0d ticks=%0d required %0d/0", state, ticks, frozen);
    end
    press_run(HOLD);
    for (int i = 0; i < PRESS_LAT; i++) step();
    checks++;
    if (run !== 1'b1) begin
      errors++;
      $display("FAIL resume_run: got %0d required 1", run);
    end
    wait_tick(20, n, ok);
    checks++;
    if (!ok || n != 4) begin
      errors++;
      $display("FAIL resume_phase: got %0d cycles (seen=%0d) required 4", n, ok);
    end
    checks++;
    if (state !== ((frozen == 5'd19) ? 5'd0 : frozen + 5'd1)) begin
      errors++;
      $display("FAIL resume_state: got %0d required after %0d", state, frozen);
    end
  endtask

  task automatic test_async_reset();
    int n;
    bit ok;
    for (int i = 0; i < 25 && state !== 5'd12; i++) wait_tick(20, n, ok);
    checks++;
    if (state !== 5'd12 || run !== 1'b1) begin
      errors++;
      $display("FAIL arst_seek: got state=%0d run=%0d required 12/1", state, run);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 5'd0 || run !== 1'b0 || tick !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate: got state=%0d run=%0d tick=%0d wrap=%0d required all 0", state, run, tick, wrap);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (run !== 1'b0 || state !== 5'd0) begin
      errors++;
      $display("FAIL arst_after: got state=%0d run=%0d required 0/0", state, run);
    end
  endtask

`ifdef CTR20_DEBOUNCE_EN
  task automatic test_debounce();
    press_run(3);
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (run !== 1'b0) begin
      errors++;
      $display("FAIL db_glitch: got %0d required 0", run);
    end
    press_run(10);
    for (int i = 0; i < PRESS_LAT - 1; i++) step();
    checks++;
    if (run !== 1'b0) begin
      errors++;
      $display("FAIL db_early: got %0d required 0", run);
    end
    step();
    checks++;
    if (run !== 1'b1) begin
      errors++;
      $display("FAIL db_press: got %0d required 1", run);
    end
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (run !== 1'b1) begin
      errors++;
      $display("FAIL db_once: got %0d required 1", run);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_clear_terminal();
    test_pause();
    test_async_reset();
`ifdef CTR20_DEBOUNCE_EN
    test_debounce();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
